reg_file_sb: RTL
================

// Module: reg_file_sb
// PURPOSE
//   Parametrised multi-register file for the CPU datapath: WIDTH-bit x DEPTH entries,
//   one synchronous write port, two asynchronous read ports with write-through bypass.
//   Adds a per-register busy scoreboard (set on issue, cleared on writeback) so the
//   decode stage can stall on RAW hazards. Sits between decode (reads/issue) and writeback.
// PARAMETERS
//   WIDTH      16  data width of every register
//   DEPTH      16  number of registers (>=2; need not be a power of two)
//   ZERO_REG   1   1: register 0 reads 0, ignores writes, never goes busy
//   RESET_VAL  0   value loaded into every register on reset (WIDTH bits)
//   AW (localparam) = $clog2(DEPTH), address width
// PORTS
//   CLK       in   1      clock, all state updates on rising edge
//   RST       in   1      synchronous reset, active-high
//   WE        in   1      write enable (writeback)
//   WA        in   AW     write address
//   WD        in   WIDTH  write data
//   RA_A      in   AW     read address, port A
//   RD_A      out  WIDTH  read data, port A
//   RA_B      in   AW     read address, port B
//   RD_B      out  WIDTH  read data, port B
//   ISSUE     in   1      mark destination register busy (instruction issued)
//   ISSUE_A   in   AW     destination address being issued
//   BUSY_A    out  1      scoreboard bit for RA_A
//   BUSY_B    out  1      scoreboard bit for RA_B
//   ALL_IDLE  out  1      1 when no register is busy
// BEHAVIOUR
//   - Reset (RST=1 at posedge): all regs <= RESET_VAL (reg0 <= 0 if ZERO_REG), all busy <= 0.
//     WE/ISSUE in the reset cycle are ignored. After reset: RD_x = RESET_VAL, BUSY_x = 0, ALL_IDLE = 1.
//   - Write: at posedge with WE=1, RST=0: reg[WA] <= WD. Latency 1 into storage.
//   - Read: RD_x combinational from RA_x. Bypass: if WE && WA==RA_x && write is legal,
//     RD_x = WD in the same cycle (zero-latency read-after-write).
//   - Scoreboard, per address at posedge: ISSUE&&ISSUE_A==a sets busy[a]; WE&&WA==a clears it;
//     both in same cycle -> busy[a] = 1 (new producer wins).
//   - BUSY_x = busy[RA_x] & ~(WE && WA==RA_x): a writeback in flight is bypassed, not stalled.
//   - ALL_IDLE = ~|busy (registered state only, no bypass).
//   - ZERO_REG=1: addr 0 writes dropped, RD_x=0 for RA_x=0, ISSUE to 0 ignored, BUSY_x=0.
//   - Addresses >= DEPTH: writes and issues ignored, RD_x = 0, BUSY_x = 0.
//   - Read ports independent; RA_A==RA_B returns identical data/busy on both.
//   - Reset mid-operation discards all pending busy bits; no write completes in that cycle.
// STRUCTURE
//   - Shared package/header: default WIDTH/DEPTH, RESET_VAL, clog2 helper for AW.
//   - Sub-module reg_scoreboard (DEPTH, AW): busy vector, set/clear priority, BUSY_A/B, ALL_IDLE.
//   - Top holds storage array, write decode, bypass muxes, range/zero-reg qualification.
// TESTING
//   1. Reset, then read all addresses -> every RD = RESET_VAL, BUSY=0, ALL_IDLE=1.
//   2. WE=1 WA=3 WD=16'hBEEF, RA_A=3 same cycle -> RD_A=BEEF immediately; next cycle WE=0 -> still BEEF.
//   3. ZERO_REG=1: WE WA=0 WD=FFFF; ISSUE_A=0 -> RD_A(RA=0)=0, BUSY_A=0, ALL_IDLE=1.
//   4. ISSUE_A=5 -> next cycle BUSY_A(RA=5)=1, ALL_IDLE=0; WE WA=5 -> BUSY_A=0 that cycle, busy cleared next.
//   5. Same cycle ISSUE_A=7 and WE WA=7 WD=0042 -> reg7=0042, busy[7]=1 afterwards.
//   6. Set busy[2], write reg4=1234, assert RST with WE WA=4 WD=9999 -> reg4=RESET_VAL, busy all 0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry,
// read-source encoding and the address-width helper.
package reg_file_sb_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_DEPTH = 16;

    // Where a read port takes its data from in the current cycle.
    typedef enum logic [1:0] {
        SRC_STORE  = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ZERO   = 2'd2
    } rd_src_e;

    // Address width for a given register count; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bundle of the register file: write port, two read
// ports, issue port and the scoreboard status outputs.
interface reg_file_sb_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);

    logic             WE;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] WD;
    logic [AW-1:0]    RA_A;
    logic [WIDTH-1:0] RD_A;
    logic [AW-1:0]    RA_B;
    logic [WIDTH-1:0] RD_B;
    logic             ISSUE;
    logic [AW-1:0]    ISSUE_A;
    logic             BUSY_A;
    logic             BUSY_B;
    logic             ALL_IDLE;

    // Pipeline side: decode issues and reads, writeback writes.
    modport master (
        output WE, WA, WD, RA_A, RA_B, ISSUE, ISSUE_A,
        input  RD_A, RD_B, BUSY_A, BUSY_B, ALL_IDLE
    );

    // Register file side.
    modport slave (
        input  WE, WA, WD, RA_A, RA_B, ISSUE, ISSUE_A,
        output RD_A, RD_B, BUSY_A, BUSY_B, ALL_IDLE
    );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, with the
// in-flight writeback masking the stall seen by the read ports.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          set_en,    // already range/zero-qualified
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,    // already range/zero-qualified
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] ra_a,
    input  logic          vld_a,     // ra_a names a real, non-hardwired register
    input  logic [AW-1:0] ra_b,
    input  logic          vld_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic          all_idle
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_en && (clr_addr == AW'(i))) busy_nxt[i] = 1'b0;
            // Applied after the clear: a new producer outranks the retiring one.
            if (set_en && (set_addr == AW'(i))) busy_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (RST) busy <= '0;
        else     busy <= busy_nxt;
    end

    // A register being written back this cycle is forwarded, so it does not stall.
    assign busy_a   = vld_a && busy[ra_a] && !(clr_en && (clr_addr == ra_a));
    assign busy_b   = vld_b && busy[ra_b] && !(clr_en && (clr_addr == ra_b));
    assign all_idle = ~|busy;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with one synchronous write port, two asynchronous bypassed
// read ports and a RAW-hazard busy scoreboard for the decode stage.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int               WIDTH     = RF_WIDTH,
    parameter int               DEPTH     = RF_DEPTH,
    parameter int               ZERO_REG  = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          CLK,
    input  logic          RST,
    reg_file_sb_if.slave  bus
);

    localparam int          AW      = addr_width(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // A live register can be written, read from storage and go busy.
    function automatic logic is_live(input logic [AW-1:0] a);
        return in_range(a) && !is_zero(a);
    endfunction

    function automatic rd_src_e rd_source(input logic [AW-1:0] ra,
                                          input logic          wr_ok,
                                          input logic [AW-1:0] wa);
        if (!is_live(ra))          return SRC_ZERO;
        if (wr_ok && (wa == ra))   return SRC_BYPASS;
        return SRC_STORE;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic             we_ok;
    logic             issue_ok;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             busy_a;
    logic             busy_b;
    logic             all_idle;

    assign we_ok    = bus.WE    && is_live(bus.WA);
    assign issue_ok = bus.ISSUE && is_live(bus.ISSUE_A);

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the storage is reset entry by entry because RESET_VAL is
            // architecturally visible; this keeps it in flops rather than RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : RESET_VAL;
            end
        end else if (we_ok) begin
            mem[bus.WA] <= bus.WD;
        end
    end

    always_comb begin
        rd_a = '0;
        case (rd_source(bus.RA_A, we_ok, bus.WA))
            SRC_BYPASS: rd_a = bus.WD;
            SRC_STORE:  rd_a = mem[bus.RA_A];
            default:    rd_a = '0;
        endcase
    end

    always_comb begin
        rd_b = '0;
        case (rd_source(bus.RA_B, we_ok, bus.WA))
            SRC_BYPASS: rd_b = bus.WD;
            SRC_STORE:  rd_b = mem[bus.RA_B];
            default:    rd_b = '0;
        endcase
    end

    reg_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .CLK      (CLK),
        .RST      (RST),
        .set_en   (issue_ok),
        .set_addr (bus.ISSUE_A),
        .clr_en   (we_ok),
        .clr_addr (bus.WA),
        .ra_a     (bus.RA_A),
        .vld_a    (is_live(bus.RA_A)),
        .ra_b     (bus.RA_B),
        .vld_b    (is_live(bus.RA_B)),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .all_idle (all_idle)
    );

    assign bus.RD_A     = rd_a;
    assign bus.RD_B     = rd_b;
    assign bus.BUSY_A   = busy_a;
    assign bus.BUSY_B   = busy_b;
    assign bus.ALL_IDLE = all_idle;

endmodule
